clock_ctrl_fsm: RTL and testbench

- Front-panel controller for the digital clock: turns debounced button pulses into time-set and alarm-set sequences.
- Holds the alarm time.
- Generates a one-cycle load strobe, plus set digits, for the timekeeping counter.
- Raises and times out the alarm ring.
- Sits between the button debouncers and the hh:mm:ss counter; all BCD digit widths match that counter.

---
 rtl/clock_ctrl_fsm_pkg.sv | 18 +
 rtl/clock_ctrl_fsm_if.sv | 41 ++++
 rtl/clock_ctrl_fsm_bcd_field_inc.sv | 35 +++
 rtl/clock_ctrl_fsm.sv | 176 +++++++++++++++++
 tb/tb_clock_ctrl_fsm.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/clock_ctrl_fsm_pkg.sv
// Shared types and constants for the clock front-panel controller.
// State codes double as the externally visible mode value.
package clock_pkg;
   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_T_HR  = 3'd1,
      ST_T_MIN = 3'd2,
      ST_A_HR  = 3'd3,
      ST_A_MIN = 3'd4
   } state_t;

   localparam int HR_MAX  = 23;
   localparam int MIN_MAX = 59;
   localparam int LH_W    = 2;
   localparam int RH_W    = 4;
   localparam int LM_W    = 3;
   localparam int RM_W    = 4;
endpackage

// File: rtl/clock_ctrl_fsm_if.sv
// Button, current-time and display/counter-load signals of the clock controller.
// The master side drives buttons and time; the slave side is the controller.
interface clock_ctrl_fsm_if;
   import clock_pkg::*;

   logic            tick_1hz;
   logic            btn_mode;
   logic            btn_alarm;
   logic            btn_inc;
   logic            alarm_en;
   logic [LH_W-1:0] cur_lh;
   logic [RH_W-1:0] cur_rh;
   logic [LM_W-1:0] cur_lm;
   logic [RM_W-1:0] cur_rm;
   logic            load_time;
   logic [LH_W-1:0] set_lh;
   logic [RH_W-1:0] set_rh;
   logic [LM_W-1:0] set_lm;
   logic [RM_W-1:0] set_rm;
   logic [LH_W-1:0] alm_lh;
   logic [RH_W-1:0] alm_rh;
   logic [LM_W-1:0] alm_lm;
   logic [RM_W-1:0] alm_rm;
   logic            alarm_ring;
   logic [2:0]      mode;
   logic            blink;

   modport master (
      output tick_1hz, btn_mode, btn_alarm, btn_inc, alarm_en,
      output cur_lh, cur_rh, cur_lm, cur_rm,
      input  load_time, set_lh, set_rh, set_lm, set_rm,
      input  alm_lh, alm_rh, alm_lm, alm_rm, alarm_ring, mode, blink
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_alarm, btn_inc, alarm_en,
      input  cur_lh, cur_rh, cur_lm, cur_rm,
      output load_time, set_lh, set_rh, set_lm, set_rm,
      output alm_lh, alm_rh, alm_lm, alm_rm, alarm_ring, mode, blink
   );
endinterface

// File: rtl/clock_ctrl_fsm_bcd_field_inc.sv
// Combinational +1 of a two-digit BCD field with wrap to 00 at MAX_VAL.
// Out-of-range inputs (bad units digit or value above MAX_VAL) also go to 00.
module bcd_field_inc #(
   parameter int TENS_W   = 2,
   parameter int MAX_TENS = 2,
   parameter int MAX_VAL  = 23
) (
   input  logic [TENS_W-1:0] i_tens,
   input  logic [3:0]        i_units,
   output logic [TENS_W-1:0] o_tens,
   output logic [3:0]        o_units
);
   localparam logic [TENS_W-1:0] L_MAX_TENS  = TENS_W'(MAX_TENS);
   localparam logic [3:0]        L_MAX_UNITS = 4'(MAX_VAL - MAX_TENS * 10);

   logic w_wrap;

   // Wrap detection and digit increment with decimal carry
   always_comb begin
      o_tens  = '0;
      o_units = 4'd0;
      w_wrap  = (i_units > 4'd9) || (i_tens > L_MAX_TENS) ||
                ((i_tens == L_MAX_TENS) && (i_units >= L_MAX_UNITS));
      if (w_wrap) begin
         o_tens  = '0;
         o_units = 4'd0;
      end else if (i_units == 4'd9) begin
         o_tens  = i_tens + TENS_W'(1);
         o_units = 4'd0;
      end else begin
         o_tens  = i_tens;
         o_units = i_units + 4'd1;
      end
   end
endmodule

// File: rtl/clock_ctrl_fsm.sv
// Front-panel controller: time/alarm edit FSM, edit timeout, alarm match and ring timer.
// All outputs are registered; set_* feed the counter alongside the load_time strobe.
module clock_ctrl_fsm
   import clock_pkg::*;
#(
   parameter int EDIT_TIMEOUT_S = 30,
   parameter int RING_S         = 10
) (
   input  logic             clk,
   input  logic             rst,
   clock_ctrl_fsm_if.slave  bus
);
   localparam int TO_W = $clog2(EDIT_TIMEOUT_S + 1);
   localparam int RG_W = $clog2(RING_S + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(EDIT_TIMEOUT_S - 1);
   localparam logic [RG_W-1:0] RG_LAST = RG_W'(RING_S - 1);

   state_t          r_state;
   logic            r_load_time, r_blink, r_alarm_ring, r_match_q;
   logic [TO_W-1:0] r_to_cnt;
   logic [RG_W-1:0] r_ring_cnt;
   logic [LH_W-1:0] r_set_lh, r_alm_lh, w_inc_lh;
   logic [RH_W-1:0] r_set_rh, r_alm_rh, w_inc_rh;
   logic [LM_W-1:0] r_set_lm, r_alm_lm, w_inc_lm;
   logic [RM_W-1:0] r_set_rm, r_alm_rm, w_inc_rm;
   logic            w_any_btn, w_consumed, w_mode, w_alarm, w_inc, w_btn_act, w_match;

   bcd_field_inc #(.TENS_W(LH_W), .MAX_TENS(HR_MAX / 10), .MAX_VAL(HR_MAX)) u_hr_inc (
      .i_tens(r_set_lh), .i_units(r_set_rh), .o_tens(w_inc_lh), .o_units(w_inc_rh)
   );
   bcd_field_inc #(.TENS_W(LM_W), .MAX_TENS(MIN_MAX / 10), .MAX_VAL(MIN_MAX)) u_min_inc (
      .i_tens(r_set_lm), .i_units(r_set_rm), .o_tens(w_inc_lm), .o_units(w_inc_rm)
   );

   // A press during ringing only dismisses the ring and is never seen by the FSM
   assign w_any_btn  = bus.btn_mode | bus.btn_alarm | bus.btn_inc;
   assign w_consumed = r_alarm_ring & w_any_btn;
   assign w_mode     = bus.btn_mode & ~w_consumed;
   assign w_alarm    = bus.btn_alarm & ~bus.btn_mode & ~w_consumed;
   assign w_inc      = bus.btn_inc & ~bus.btn_alarm & ~bus.btn_mode & ~w_consumed;
   assign w_match    = bus.alarm_en && (bus.cur_lh == r_alm_lh) && (bus.cur_rh == r_alm_rh) &&
                       (bus.cur_lm == r_alm_lm) && (bus.cur_rm == r_alm_rm);

   // Decode whether the current state acts on the selected button
   always_comb begin
      w_btn_act = 1'b0;
      case (r_state)
         ST_T_HR, ST_T_MIN: w_btn_act = w_mode | w_inc;
         ST_A_HR, ST_A_MIN: w_btn_act = w_mode | w_alarm | w_inc;
         default:           w_btn_act = 1'b0;
      endcase
   end

   // Edit FSM with set/alarm digit registers, load strobe, blink and edit timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_load_time <= 1'b0;
         r_blink     <= 1'b0;
         r_to_cnt    <= '0;
         {r_set_lh, r_set_rh, r_set_lm, r_set_rm} <= '0;
         {r_alm_lh, r_alm_rh, r_alm_lm, r_alm_rm} <= '0;
      end else begin
         r_load_time <= 1'b0;
         if (r_state != ST_RUN && !w_btn_act && bus.tick_1hz) begin
            if (r_to_cnt == TO_LAST) begin
               r_state  <= ST_RUN;
               r_to_cnt <= '0;
               r_blink  <= 1'b0;
            end else begin
               r_to_cnt <= r_to_cnt + TO_W'(1);
               r_blink  <= ~r_blink;
            end
         end
         if (w_btn_act) begin
            r_to_cnt <= '0;
            r_blink  <= 1'b1;
         end
         case (r_state)
            ST_RUN: begin
               r_blink  <= 1'b0;
               r_to_cnt <= '0;
               if (w_mode) begin
                  r_state <= ST_T_HR;
                  r_blink <= 1'b1;
                  {r_set_lh, r_set_rh, r_set_lm, r_set_rm} <=
                     {bus.cur_lh, bus.cur_rh, bus.cur_lm, bus.cur_rm};
               end else if (w_alarm) begin
                  r_state <= ST_A_HR;
                  r_blink <= 1'b1;
                  {r_set_lh, r_set_rh, r_set_lm, r_set_rm} <=
                     {r_alm_lh, r_alm_rh, r_alm_lm, r_alm_rm};
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_T_HR, ST_A_HR: begin
               if (w_mode) begin
                  r_state <= (r_state == ST_T_HR) ? ST_T_MIN : ST_RUN;
                  r_blink <= (r_state == ST_T_HR);
               end else if (w_alarm) begin
                  r_state <= ST_A_MIN;
               end else if (w_inc) begin
                  {r_set_lh, r_set_rh} <= {w_inc_lh, w_inc_rh};
               end else begin
                  r_set_lh <= r_set_lh;
               end
            end
            ST_T_MIN, ST_A_MIN: begin
               if (w_mode) begin
                  r_state     <= ST_RUN;
                  r_blink     <= 1'b0;
                  r_load_time <= (r_state == ST_T_MIN);
               end else if (w_alarm) begin
                  r_state <= ST_RUN;
                  r_blink <= 1'b0;
                  {r_alm_lh, r_alm_rh, r_alm_lm, r_alm_rm} <=
                     {r_set_lh, r_set_rh, r_set_lm, r_set_rm};
               end else if (w_inc) begin
                  {r_set_lm, r_set_rm} <= {w_inc_lm, w_inc_rm};
               end else begin
                  r_set_lm <= r_set_lm;
               end
            end
            default: begin
               r_state  <= ST_RUN;
               r_blink  <= 1'b0;
               r_to_cnt <= '0;
            end
         endcase
      end
   end

   // Alarm match edge detection, ring duration, dismiss and disarm
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alarm_ring <= 1'b0;
         r_ring_cnt   <= '0;
         r_match_q    <= 1'b0;
      end else begin
         r_match_q <= w_match;
         if (!bus.alarm_en) begin
            r_alarm_ring <= 1'b0;
            r_ring_cnt   <= '0;
         end else if (w_match && !r_match_q) begin
            r_alarm_ring <= 1'b1;
            r_ring_cnt   <= '0;
         end else if (r_alarm_ring && w_any_btn) begin
            r_alarm_ring <= 1'b0;
            r_ring_cnt   <= '0;
         end else if (r_alarm_ring && bus.tick_1hz) begin
            if (r_ring_cnt == RG_LAST) begin
               r_alarm_ring <= 1'b0;
               r_ring_cnt   <= '0;
            end else begin
               r_ring_cnt <= r_ring_cnt + RG_W'(1);
            end
         end else begin
            r_ring_cnt <= r_ring_cnt;
         end
      end
   end

   assign bus.load_time  = r_load_time;
   assign bus.set_lh     = r_set_lh;
   assign bus.set_rh     = r_set_rh;
   assign bus.set_lm     = r_set_lm;
   assign bus.set_rm     = r_set_rm;
   assign bus.alm_lh     = r_alm_lh;
   assign bus.alm_rh     = r_alm_rh;
   assign bus.alm_lm     = r_alm_lm;
   assign bus.alm_rm     = r_alm_rm;
   assign bus.alarm_ring = r_alarm_ring;
   assign bus.mode       = r_state;
   assign bus.blink      = r_blink;
endmodule

// File: tb/tb_clock_ctrl_fsm.sv
// Directed scoreboard bench for clock_ctrl_fsm: time set, priority, reset, timeout, alarm ring.
module tb_clock_ctrl_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clock_ctrl_fsm_if bus();
   clock_ctrl_fsm #(.EDIT_TIMEOUT_S(30), .RING_S(10)) dut (.clk(clk), .rst(rst), .bus(bus));

   int    checks = 0;
   int    errors = 0;
   int    lt_cnt = 0;
   int    lt_before = 0;
   int    exp_q[$];
   string tag_q[$];

   always @(negedge clk) if (bus.load_time === 1'b1) lt_cnt++;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_val(input string tag, input int v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic chk(input int obs);
      int    e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
   endtask

   task automatic pulse(input logic m, input logic a, input logic i);
      bus.btn_mode = m; bus.btn_alarm = a; bus.btn_inc = i;
      step(1);
      bus.btn_mode = 1'b0; bus.btn_alarm = 1'b0; bus.btn_inc = 1'b0;
   endtask

   task automatic inc_n(input int n);
      for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_1hz = 1'b1;
         step(1);
         bus.tick_1hz = 1'b0;
         step(1);
      end
   endtask

   task automatic set_cur(input int lh, input int rh, input int lm, input int rm);
      bus.cur_lh = 2'(lh); bus.cur_rh = 4'(rh); bus.cur_lm = 3'(lm); bus.cur_rm = 4'(rm);
   endtask

   function automatic int set_v();
      return int'(bus.set_lh) * 1000 + int'(bus.set_rh) * 100 + int'(bus.set_lm) * 10 + int'(bus.set_rm);
   endfunction

   function automatic int alm_v();
      return int'(bus.alm_lh) * 1000 + int'(bus.alm_rh) * 100 + int'(bus.alm_lm) * 10 + int'(bus.alm_rm);
   endfunction

   initial begin
      bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_alarm = 1'b0; bus.btn_inc = 1'b0;
      bus.alarm_en = 1'b0;
      set_cur(0, 0, 0, 0);
      step(2);
      rst = 1'b0;
      expect_val("rst_mode", 0);  chk(int'(bus.mode));
      expect_val("rst_load", 0);  chk(int'(bus.load_time));
      expect_val("rst_set", 0);   chk(set_v());
      expect_val("rst_alm", 0);   chk(alm_v());
      expect_val("rst_ring", 0);  chk(int'(bus.alarm_ring));
      expect_val("rst_blink", 0); chk(int'(bus.blink));

      // time set 14:37 -> +10 h, +25 min
      set_cur(1, 4, 3, 7);
      pulse(1'b1, 1'b0, 1'b0);
      expect_val("ts_mode_thr", 1);  chk(int'(bus.mode));
      expect_val("ts_preload", 1437); chk(set_v());
      expect_val("ts_blink", 1);     chk(int'(bus.blink));
      inc_n(10);
      expect_val("ts_hr_wrap", 37);  chk(set_v());
      pulse(1'b1, 1'b0, 1'b0);
      expect_val("ts_mode_tmin", 2); chk(int'(bus.mode));
      inc_n(25);
      expect_val("ts_min_wrap", 2);  chk(set_v());
      lt_before = lt_cnt;
      pulse(1'b1, 1'b0, 1'b0);
      expect_val("ts_load_hi", 1);   chk(int'(bus.load_time));
      expect_val("ts_mode_run", 0);  chk(int'(bus.mode));
      expect_val("ts_set_final", 2); chk(set_v());
      step(1);
      expect_val("ts_load_lo", 0);   chk(int'(bus.load_time));
      expect_val("ts_load_cnt", 1);  chk(lt_cnt - lt_before);

      // priority
      pulse(1'b1, 1'b1, 1'b0);
      expect_val("pri_mode_alarm", 1); chk(int'(bus.mode));
      pulse(1'b1, 1'b0, 1'b1);
      expect_val("pri_mode_inc", 2);   chk(int'(bus.mode));
      expect_val("pri_hr_same", 1437); chk(set_v());

      // reset mid-edit
      lt_before = lt_cnt;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      expect_val("mid_rst_mode", 0);  chk(int'(bus.mode));
      expect_val("mid_rst_set", 0);   chk(set_v());
      expect_val("mid_rst_alm", 0);   chk(alm_v());
      expect_val("mid_rst_blink", 0); chk(int'(bus.blink));
      step(1);
      expect_val("mid_rst_noload", 0); chk(lt_cnt - lt_before);

      // edit timeout
      lt_before = lt_cnt;
      pulse(1'b1, 1'b0, 1'b0);
      inc_n(3);
      expect_val("to_set", 1737);   chk(set_v());
      ticks(1);
      expect_val("to_blink_tog", 0); chk(int'(bus.blink));
      ticks(28);
      expect_val("to_before", 1);   chk(int'(bus.mode));
      ticks(1);
      expect_val("to_mode_run", 0); chk(int'(bus.mode));
      expect_val("to_noload", 0);   chk(lt_cnt - lt_before);
      expect_val("to_alm", 0);      chk(alm_v());

      // alarm set 06:30
      set_cur(1, 2, 0, 0);
      pulse(1'b0, 1'b1, 1'b0);
      expect_val("as_mode_ahr", 3);  chk(int'(bus.mode));
      expect_val("as_preload", 0);   chk(set_v());
      inc_n(6);
      pulse(1'b0, 1'b1, 1'b0);
      expect_val("as_mode_amin", 4); chk(int'(bus.mode));
      inc_n(30);
      pulse(1'b0, 1'b1, 1'b0);
      expect_val("as_mode_run", 0);  chk(int'(bus.mode));
      expect_val("as_alm", 630);     chk(alm_v());
      expect_val("as_noload", 0);    chk(lt_cnt - lt_before);

      // ring and time-out of the ring
      set_cur(0, 6, 2, 9);
      bus.alarm_en = 1'b1;
      step(2);
      expect_val("ring_pre", 0);    chk(int'(bus.alarm_ring));
      set_cur(0, 6, 3, 0);
      step(1);
      expect_val("ring_on", 1);     chk(int'(bus.alarm_ring));
      ticks(9);
      expect_val("ring_9", 1);      chk(int'(bus.alarm_ring));
      ticks(1);
      expect_val("ring_10", 0);     chk(int'(bus.alarm_ring));
      ticks(3);
      expect_val("ring_noretrig", 0); chk(int'(bus.alarm_ring));

      // dismiss by button
      set_cur(0, 6, 3, 1);
      step(1);
      set_cur(0, 6, 3, 0);
      step(1);
      expect_val("dis_ring_on", 1); chk(int'(bus.alarm_ring));
      pulse(1'b1, 1'b0, 1'b0);
      expect_val("dis_ring_off", 0); chk(int'(bus.alarm_ring));
      expect_val("dis_mode", 0);     chk(int'(bus.mode));
      step(1);
      expect_val("dis_mode_hold", 0); chk(int'(bus.mode));
      expect_val("dis_blink", 0);     chk(int'(bus.blink));

      // disarm clears ring
      set_cur(0, 6, 3, 1);
      step(1);
      set_cur(0, 6, 3, 0);
      step(1);
      expect_val("en_ring_on", 1);  chk(int'(bus.alarm_ring));
      bus.alarm_en = 1'b0;
      step(1);
      expect_val("en_ring_off", 0); chk(int'(bus.alarm_ring));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
